pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor split into WIDTH/CHUNK registered CHUNK-bit ripple stages.
// Latency: WIDTH/CHUNK cycles from accept to out_valid; sustains one beat per cycle.
// Backpressure: one global enable freezes every stage while out_valid && !out_ready; in_ready mirrors it.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset (0 = reset)
//   in_valid/in_ready operand handshake; a, b, cin, sub are sampled on accept
//   out_valid/out_ready result handshake; sum, cout (and ovf) hold while stalled
//   sub=1 computes a - b (cin ignored, cout=1 means no borrow); sub=0 computes a + b + cin
// Optional feature: define PIPE_ADDER_OVF_EN to add the ovf (signed overflow) output.
//
// Each stage register holds a WIDTH-bit word that is rotated right by CHUNK bits per stage:
// the low CHUNK bits are the next A slice to add, and each stage's result slice enters at the
// top. After STAGES rotations the result slices sit in their natural positions, which gives
// both the operand skew and the result deskew without any padding flops. Pending B slices
// live in a triangular packed vector, one shrinking field per stage.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
  // Total pending-B bits across stages 0..STAGES-2: CHUNK*(STAGES-1) + ... + CHUNK.
  localparam int BBW    = (STAGES > 1) ? (CHUNK * STAGES * (STAGES - 1)) / 2 : 1;

  logic                         en;
  logic [WIDTH-1:0]             b_eff;
  logic                         c0;
  logic [STAGES-1:0]            stg_vld;
  logic [STAGES-1:0]            stg_cy;
  logic [STAGES-1:0][WIDTH-1:0] stg_res;
  logic [BBW-1:0]               stg_b;

  // Subtraction is a + ~b + 1, so sub forces the carry-in high.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  // Whole pipe advances together; a full output slot only blocks when downstream refuses it.
  assign en       = !stg_vld[STAGES-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int PW = WIDTH - k * CHUNK;  // B bits still pending at this stage's input

    logic             sv;
    logic             sc;
    logic [WIDTH-1:0] sa;
    logic [PW-1:0]    sb;
    logic [CHUNK:0]   add_d;
    logic [WIDTH-1:0] res_d;
    logic             vld_q;
    logic             cy_q;
    logic [WIDTH-1:0] res_q;

    if (k == 0) begin : g_src_in
      assign sv = in_valid;
      assign sc = c0;
      assign sa = a;
      assign sb = b_eff;
    end else begin : g_src_prev
      // Offset of stage k-1's pending-B field inside stg_b.
      localparam int POFF = CHUNK * ((k - 1) * STAGES - ((k - 1) * k) / 2);
      assign sv = stg_vld[k-1];
      assign sc = stg_cy[k-1];
      assign sa = stg_res[k-1];
      assign sb = stg_b[POFF +: PW];
    end

    assign add_d = {1'b0, sa[CHUNK-1:0]} + {1'b0, sb[CHUNK-1:0]} + {{CHUNK{1'b0}}, sc};
    // Consume the low A slice, insert this stage's result slice at the top.
    assign res_d = (sa >> CHUNK) | (WIDTH'(add_d[CHUNK-1:0]) << (WIDTH - CHUNK));

    // Data only loads with a real beat, so bubbles leave the previous result in place.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else if (en) begin
        vld_q <= sv;
        if (sv) begin
          cy_q  <= add_d[CHUNK];
          res_q <= res_d;
        end
      end
    end

    assign stg_vld[k] = vld_q;
    assign stg_cy[k]  = cy_q;
    assign stg_res[k] = res_q;

    if (k < STAGES - 1) begin : g_pend
      localparam int OOFF = CHUNK * (k * STAGES - (k * (k + 1)) / 2);
      localparam int OW   = PW - CHUNK;
      logic [OW-1:0] pb_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pb_q <= '0;
        end else if (en && sv) begin
          pb_q <= sb[PW-1:CHUNK];
        end
      end

      assign stg_b[OOFF +: OW] = pb_q;
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;
      // a^b^sum at the MSB recovers the carry into the MSB; compare it with the carry out.
      assign ovf_d = sa[CHUNK-1] ^ sb[CHUNK-1] ^ add_d[CHUNK-1] ^ add_d[CHUNK];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ovf_q <= 1'b0;
        end else if (en && sv) begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end
`endif
  end

  assign out_valid = stg_vld[STAGES-1];
  assign sum       = stg_res[STAGES-1];
  assign cout      = stg_cy[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of pipelined_adder at WIDTH=8, CHUNK=4 (two stages).
// Latency: expects results two edges after accept.
// Backpressure: exercises stalls, bubbles, back-to-back streams and mid-flight reset.
module tb_pipelined_adder;

  localparam int WIDTH = 8;
  localparam int CHUNK = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

`ifndef PIPE_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single isolated beat: accept, confirm nothing after one edge, then check the result.
  task automatic apply_vec(input vec_t v);
    in_valid = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("vec_latency_not_1", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("vec_out_valid", {63'd0, out_valid}, 64'd1);
    chk("vec_sum_cout", {55'd0, cout, sum}, {55'd0, v.exp_cout, v.exp_sum});
`ifdef PIPE_ADDER_OVF_EN
    chk("vec_ovf", {63'd0, ovf}, {63'd0, v.exp_ovf});
`endif
    @(posedge clk); #1;
  endtask

  // Stream beat i carries a=start+i, b=2*(start+i); expected {cout,sum} = 3*(start+i).
  // Pattern bit c controls in_valid / out_ready in cycle c; vld_pat records observed out_valid.
  task automatic run_stream(input int n_beats, input int start, input int n_cyc,
                            input logic [63:0] iv_pat, input logic [63:0] ordy_pat,
                            output logic [63:0] vld_pat, output int n_rcv);
    int snd;
    int rcv;
    logic [8:0] exp_v;
    snd = 0;
    rcv = 0;
    vld_pat = '0;
    for (int c = 0; c < n_cyc; c++) begin
      in_valid  = iv_pat[c] && (snd < n_beats);
      a         = 8'(start + snd);
      b         = 8'(2 * (start + snd));
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = ordy_pat[c];
      @(negedge clk);
      if (out_ready) chk("in_ready_when_out_ready", {63'd0, in_ready}, 64'd1);
      if (out_valid) begin
        vld_pat[c] = 1'b1;
        exp_v = 9'(3 * (start + rcv));
        chk("stream_sum_cout", {55'd0, cout, sum}, {55'd0, exp_v});
        if (!out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (out_ready) begin
          chk("no_extra_beat", {63'd0, (rcv < n_beats)}, 64'd1);
          rcv++;
        end
      end
      if (in_valid && in_ready) snd++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drained", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    n_rcv = rcv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[12];
    logic [63:0] vp;
    int          nr;

    vecs[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};  // cin ignored in sub mode
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};  // carry crosses the chunk boundary
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #22 rst = 1'b1;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_sum_cout", {55'd0, cout, sum}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

    // 16 back-to-back beats: first result two cycles after first accept, then 16 in a row.
    run_stream(16, 0, 20, '1, '1, vp, nr);
    chk("b2b_valid_pattern", vp, 64'h0000_0000_0003_FFFC);
    chk("b2b_count", 64'(nr), 64'd16);

    // Five-cycle stall mid-stream.
    run_stream(10, 0, 20, '1, 64'hFFFF_FFFF_FFFF_FE0F, vp, nr);
    chk("stall_valid_pattern", vp, 64'h0000_0000_0001_FFFC);
    chk("stall_count", 64'(nr), 64'd10);

    // Alternating bubbles.
    run_stream(8, 20, 22, 64'h5555_5555_5555_5555, '1, vp, nr);
    chk("bubble_valid_pattern", vp, 64'h0000_0000_0001_5554);
    chk("bubble_count", 64'(nr), 64'd8);

    // Reset with two beats in flight.
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h03; b = 8'h04;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_reset_sum", {56'd0, sum}, 64'h03);
    #1 rst = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum_cout", {55'd0, cout, sum}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_stream(1, 100, 6, '1, '1, vp, nr);
    chk("post_reset_valid_pattern", vp, 64'h4);
    chk("post_reset_count", 64'(nr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
